// File: rtl/uart_pkg.sv
// Definitions shared by the uart_tx / uart_rx pair: frame geometry defaults,
// the frame FSM encoding and the even-parity helper.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 7;
    localparam int DEF_OVERSAMPLE = 16;

    // Widest payload the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic calc_parity(input logic [PARITY_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts clk_en pulses while run is high and flags
// bit_end on the last tick of each serial bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic run,
    output logic bit_end
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = run && clk_en && (cnt_q == CNT_W'(OVERSAMPLE - 1));

    // Held at zero while idle so every new frame starts a full bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (clk_en) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, even parity, stop; registered tx.
// Optional one-deep holding register enabled by defining UART_TX_HOLD_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_clk_en,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 parity_out
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;
    logic                 bit_end;
    logic                 timer_run;
`ifdef UART_TX_HOLD_EN
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
`endif

    assign timer_run = (state_q != ST_IDLE);

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clk_en (tx_clk_en),
        .run    (timer_run),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_HOLD_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        load      = 1'b0;
        load_data = tx_data;
`ifdef UART_TX_HOLD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
`ifdef UART_TX_HOLD_EN
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_data   = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART_TX_HOLD_EN
        // A request on the closing stop edge is dropped, matching the non-hold build.
        if (tx_start && (state_q != ST_IDLE) && !hold_full_q && !((state_q == ST_STOP) && bit_end)) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
`endif
        if (load) begin
            state_d   = ST_START;
            shift_d   = load_data;
            bit_cnt_d = '0;
            parity_d  = calc_parity(PARITY_W'(load_data));
        end
    end

    // Outputs are computed from the next state so the registered line changes on the same edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && bit_end;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign parity_out = parity_q;

endmodule
